// File: rtl/shift_register_universal.sv
`default_nettype none
// ============================================================================
// Module   : shift_register_universal
// Purpose  : WIDTH-bit bidirectional shift register with four fill modes,
//            parallel load and an autonomous N-shift burst with busy/done.
// Revision : 1.0
// ============================================================================
module shift_register_universal #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             enable_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic             serial_i,
    input  logic             start_i,
    input  logic [CNT_W-1:0] count_i,
    output logic [WIDTH-1:0] data_o,
    output logic             serial_o,
    output logic             busy_o,
    output logic             done_o
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam logic [1:0] MODE_SERIAL = 2'b00;
    localparam logic [1:0] MODE_ROTATE = 2'b01;
    localparam logic [1:0] MODE_ARITH  = 2'b10;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] reg_q,   reg_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dir_q,   dir_d;
    logic [1:0]       mode_q,  mode_d;
    logic             done_q,  done_d;

    // One shift step; dir=1 moves bits toward the MSB.
    function automatic logic [WIDTH-1:0] shift_step(
        input logic [WIDTH-1:0] v,
        input logic             dir,
        input logic [1:0]       mode,
        input logic             sin
    );
        logic fill;
        fill = 1'b0;
        if (dir) begin
            case (mode)
                MODE_SERIAL: fill = sin;
                MODE_ROTATE: fill = v[WIDTH-1];
                default:     fill = 1'b0;
            endcase
            shift_step = {v[WIDTH-2:0], fill};
        end else begin
            case (mode)
                MODE_SERIAL: fill = sin;
                MODE_ROTATE: fill = v[0];
                MODE_ARITH:  fill = v[WIDTH-1];
                default:     fill = 1'b0;
            endcase
            shift_step = {fill, v[WIDTH-1:1]};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        reg_d   = reg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_i) begin
                    reg_d = data_i;
                end else if (start_i) begin
                    if (count_i != '0) begin
                        dir_d   = dir_i;
                        mode_d  = mode_i;
                        cnt_d   = count_i;
                        state_d = ST_BURST;
                    end else begin
                        done_d = 1'b1;
                    end
                end else if (enable_i) begin
                    reg_d = shift_step(reg_q, dir_i, mode_i, serial_i);
                end
            end
            ST_BURST: begin
                if (load_i) begin
                    // Abort: no completion pulse for a cancelled burst.
                    reg_d   = data_i;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    reg_d = shift_step(reg_q, dir_q, mode_q, serial_i);
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            reg_q   <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            mode_q  <= 2'b00;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            reg_q   <= reg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    logic dir_sel;
    assign dir_sel  = (state_q == ST_BURST) ? dir_q : dir_i;
    assign data_o   = reg_q;
    assign serial_o = dir_sel ? reg_q[WIDTH-1] : reg_q[0];
    assign busy_o   = (state_q == ST_BURST);
    assign done_o   = done_q;

endmodule
`default_nettype wire
